// File: rtl/uart_host_port_if.sv
// Host-side request/acknowledge port of the UART bus-initiator engine.
// The host drives the request fields; the engine returns status and read data.
interface uart_host_port_if;
  logic       req;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       ready;
  logic       done;
  logic [7:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ready, done, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ready, done, rdata
  );
endinterface

// File: rtl/uart_host_port.sv
// Sequences host register accesses onto the UART CPU bus as setup/strobe/hold phases
// and synchronises the peripheral's active-low interrupt into the CLK domain.
module uart_host_port #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_host_port_if.slave      host,
  output logic                 irq,
  output logic [1:0]           ADDR,
  output logic                 NCS,
  output logic                 NO,
  output logic                 NW,
  inout  wire  [7:0]           DATA,
  input  logic                 NINT
);

  localparam int unsigned MaxSh  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int unsigned MaxCyc = (MaxSh > STROBE_CYCLES) ? MaxSh : STROBE_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            we_q;
  logic [1:0]      addr_q;
  logic [7:0]      wdata_q;
  logic            ncs_q;
  logic            no_q;
  logic            nw_q;
  logic            drive_q;
  logic            ready_q;
  logic            done_q;
  logic [7:0]      rdata_q;
  logic [1:0]      sync_q;

  // Every bus-facing output is a flop so strobes and the drive enable cannot glitch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 2'b00;
      wdata_q <= 8'h00;
      ncs_q   <= 1'b1;
      no_q    <= 1'b1;
      nw_q    <= 1'b1;
      drive_q <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (host.req) begin
            we_q    <= host.we;
            addr_q  <= host.addr;
            wdata_q <= host.wdata;
            cnt_q   <= SetupLd;
            ncs_q   <= 1'b0;
            drive_q <= host.we;
            ready_q <= 1'b0;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          if (cnt_q == '0) begin
            cnt_q   <= StrobeLd;
            nw_q    <= ~we_q;
            no_q    <= we_q;
            state_q <= StStrobe;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StStrobe: begin
          if (cnt_q == '0) begin
            cnt_q   <= HoldLd;
            nw_q    <= 1'b1;
            no_q    <= 1'b1;
            if (!we_q) begin
              rdata_q <= DATA;
            end
            state_q <= StHold;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StHold: begin
          if (cnt_q == '0) begin
            ncs_q   <= 1'b1;
            drive_q <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-flop synchroniser; reset to the inactive (high) level of NINT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], NINT};
    end
  end

  assign irq        = ~sync_q[1];
  assign ADDR       = addr_q;
  assign NCS        = ncs_q;
  assign NO         = no_q;
  assign NW         = nw_q;
  assign DATA       = drive_q ? wdata_q : 8'hzz;
  assign host.ready = ready_q;
  assign host.done  = done_q;
  assign host.rdata = rdata_q;

endmodule

// File: doc/uart_host_port.md
# uart_host_port

Bus-initiator engine that drives the UART peripheral's CPU-side register interface from a simple request/acknowledge host port. It sequences each register access into setup, strobe and hold phases on the 2-bit address, active-low chip select, active-low read and write strobes and shared tristate data bus. It captures read data and returns it to the host. It also synchronises the peripheral's active-low interrupt into the host clock domain.

## Interface
Parameters:
- SETUP_CYCLES, 1, cycles NCS/ADDR (and write data) are valid before the strobe; ≥1
- STROBE_CYCLES, 2, cycles NO or NW is held low; ≥1
- HOLD_CYCLES, 1, cycles NCS/ADDR/data are held after the strobe; ≥1

Ports:
- CLK  in  1  the block's single clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- req  in  1  host access request, sampled only while ready=1
- we  in  1  1 = register write, 0 = register read; sampled with req
- addr  in  2  register address; sampled with req
- wdata  in  8  write data; sampled with req
- ready  out  1  engine idle, able to accept req
- done  out  1  one-cycle pulse at transaction end
- rdata  out  8  last read data; holds until the next read completes
- irq  out  1  synchronised, active-high copy of ~NINT
- ADDR  out  2  peripheral register address
- NCS  out  1  negative chip select
- NO  out  1  negative read enable
- NW  out  1  negative write enable
- DATA  inout  8  shared data bus; driven only during writes
- NINT  in  1  negative interrupt from peripheral, asynchronous

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A down-counter, sized for max(parameter), times each phase.
- IDLE: ready=1, NCS=NO=NW=1, DATA high-Z.
  - A rising edge with req=1 latches addr/we/wdata, loads the counter with SETUP_CYCLES-1 and enters SETUP.
- SETUP: NCS=0, ADDR=latched addr, NO=NW=1. On writes, DATA is driven with latched wdata.
  - At counter 0, load STROBE_CYCLES-1 and enter STROBE.
- STROBE: NCS=0; NW=0 for a write, NO=0 for a read. During a read, DATA is high-Z.
  - On the edge leaving STROBE, a read captures DATA into rdata.
  - At counter 0, load HOLD_CYCLES-1 and enter HOLD.
- HOLD: NCS=0, NO=NW=1, ADDR held. On writes, DATA is still driven.
  - At counter 0, enter IDLE with done=1 registered.
- done is high for exactly the first IDLE cycle after HOLD. ready is also 1 in that cycle, so a req there is accepted (back-to-back).
- Any req while ready=0 is ignored. Nothing is queued.
- ADDR, NCS, NO, NW and the DATA drive enable come straight from flops, so they are glitch-free.
  - NO and NW are never low simultaneously.
  - The DATA drive enable is never asserted during a read.
- irq passes ~NINT through a 2-flop synchroniser.

## Timing
- Reset (asynchronous, immediate, including mid-transaction):
  - state=IDLE, ready=1, done=0, rdata=8'h00
  - ADDR=2'b00, NCS=NO=NW=1, DATA high-Z
  - synchroniser flops=1, so irq=0
- After RST deasserts, the first edge can accept req.
- Transaction length: the accept edge is followed by SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES cycles with NCS=0, then the done cycle.
  - With defaults: 4 cycles NCS low, done in the 5th cycle after accept.
- Minimum NCS-high gap between back-to-back accesses: 1 cycle (the done/IDLE cycle).
- Read data latency: rdata is valid in the done cycle and stays stable afterward.
- Write data: DATA is driven from the first SETUP cycle through the last HOLD cycle, and released entering IDLE.
- irq latency: 2–3 CLK edges after a NINT transition. No filtering of pulses shorter than one cycle is required.

## Test plan
- Write at defaults: req, we=1, addr=2, wdata=8'hA5 → NCS low 4 cycles; NW low in cycles 2–3 only; DATA=A5 in cycles 1–4; ADDR=2; done pulse in cycle 5; NO stays 1.
- Read at defaults: bench drives DATA=8'h3C while NO=0 at addr=1 → rdata=3C at the done pulse; block never drives DATA; NW stays 1.
- Back-to-back: hold req=1 for two writes (addr 0 then 3) → exactly 1 cycle with NCS=1 between them; two done pulses 5 cycles apart.
- Busy ignore: pulse req with addr=1 mid-STROBE of a write to addr=0 → no extra transaction; only addr 0 appears on ADDR.
- Reset mid-strobe of a write: assert RST → same cycle NCS=NO=NW=1 and DATA high-Z; no done pulse; rdata=00; next req after release completes normally.
- Interrupt sync: drive NINT low → irq=1 within 3 edges; drive NINT high → irq=0 within 3 edges. Repeat with SETUP_CYCLES=3, STROBE_CYCLES=4, HOLD_CYCLES=2 → NCS low 9 cycles per access.
